// File: rtl/dispatch_stage_pkg.sv
// Shared decode/dispatch types: control bus, buffered entry, buffer states.
package dispatch_stage_pkg;

  localparam int DISP_XLEN = 32;

  localparam logic [6:0] OPC_ALU   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Decoded control signals handed from decode to dispatch.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_op;
    logic       alloc_rob_entry;
    logic       alloc_ldq_entry;
    logic       alloc_stq_entry;
  } control_signal_bus;

  // One buffered instruction.
  typedef struct packed {
    control_signal_bus       ctrl;
    logic [DISP_XLEN-1:0]    imm;
    logic [DISP_XLEN-1:0]    pc;
  } dispatch_entry_t;

  // Occupancy of the two-entry buffer; bit0 = head valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b11
  } buf_state_e;

  // True when every structure the instruction needs has room.
  function automatic logic res_avail(control_signal_bus c, logic rob_full,
                                     logic ldq_full, logic stq_full);
    return !(c.alloc_rob_entry && rob_full) &&
           !(c.alloc_ldq_entry && ldq_full) &&
           !(c.alloc_stq_entry && stq_full);
  endfunction

endpackage

// File: rtl/dispatch_stage_skid_buffer.sv
// Two-entry skid buffer: head + skid register, ready driven from state only.
module skid_buffer
  import dispatch_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         pop_i,
  output logic         head_valid_o,
  output logic [W-1:0] head_data_o
);

  buf_state_e   state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;

  // Ready is purely registered, so no path from downstream back to decode.
  assign in_ready_o   = (state_q != BUF_TWO);
  assign head_valid_o = (state_q != BUF_EMPTY);
  assign head_data_o  = head_q;

  // Occupancy FSM and payload moves; flush only clears occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_valid_i) begin
            head_q  <= in_data_i;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_valid_i && pop_i) begin
            head_q <= in_data_i;
          end else if (in_valid_i) begin
            skid_q  <= in_data_i;
            state_q <= BUF_TWO;
          end else if (pop_i) begin
            state_q <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // Input is blocked here (in_ready low), only a pop can happen.
          if (pop_i) begin
            head_q  <= skid_q;
            state_q <= BUF_ONE;
          end
        end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: skid-buffers decoded instructions, gates on ROB/LDQ/STQ
// space, pulses allocate strobes on dispatch, counts dispatches and stalls.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int XLEN  = DISP_XLEN,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  control_signal_bus in_control_signals,
  input  logic [XLEN-1:0]   in_immediate,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              rob_full,
  input  logic              ldq_full,
  input  logic              stq_full,
  output logic              rob_alloc,
  output logic              ldq_alloc,
  output logic              stq_alloc,
  output logic              out_valid,
  input  logic              out_ready,
  output control_signal_bus out_control_signals,
  output logic [XLEN-1:0]   out_immediate,
  output logic [XLEN-1:0]   out_pc,
  output logic [CNT_W-1:0]  dispatched_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int W = $bits(dispatch_entry_t);

  dispatch_entry_t   in_entry;
  dispatch_entry_t   head;
  logic [W-1:0]      head_raw;
  logic              head_valid;
  logic              res_ok;
  logic              fire;
  logic              stall;
  logic [CNT_W-1:0]  disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_entry.ctrl = in_control_signals;
  assign in_entry.imm  = in_immediate;
  assign in_entry.pc   = in_pc;

  skid_buffer #(.W(W)) u_skid (
    .clk          (clk),
    .rst_n        (reset_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_entry),
    .pop_i        (fire),
    .head_valid_o (head_valid),
    .head_data_o  (head_raw)
  );

  assign head = dispatch_entry_t'(head_raw);

  // Only structures the head actually needs can block it.
  assign res_ok    = res_avail(head.ctrl, rob_full, ldq_full, stq_full);
  assign out_valid = head_valid && res_ok && !flush;
  assign fire      = out_valid && out_ready;
  assign stall     = head_valid && !res_ok && !flush;

  assign rob_alloc = fire && head.ctrl.alloc_rob_entry;
  assign ldq_alloc = fire && head.ctrl.alloc_ldq_entry;
  assign stq_alloc = fire && head.ctrl.alloc_stq_entry;

  assign out_control_signals = head.ctrl;
  assign out_immediate       = head.imm;
  assign out_pc              = head.pc;

  // Counter next-state; both wrap naturally and ignore flush.
  always_comb begin
    disp_cnt_d  = disp_cnt_q  + (fire  ? CNT_W'(1) : CNT_W'(0));
    stall_cnt_d = stall_cnt_q + (stall ? CNT_W'(1) : CNT_W'(0));
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      disp_cnt_q  <= disp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dispatched_count = disp_cnt_q;
  assign stall_count      = stall_cnt_q;

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Pipeline stage directly downstream of instruction decode. It registers each decoded instruction (control signal bus, immediate, PC) in a two-entry skid buffer. It holds the instruction until the ROB, load queue and store queue can accept the entries it requests, then hands it to rename/issue while pulsing the matching allocate strobes. It also provides flush on misprediction and two performance counters.

## Interface
- XLEN, 32, datapath width of immediate and PC
- CNT_W, 32, width of the performance counters
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  squash every buffered instruction (branch mispredict/exception)
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept an instruction this cycle
- in_control_signals  input  control_signal_bus  decoded control signals
- in_immediate  input  XLEN  decoded immediate
- in_pc  input  XLEN  instruction PC
- rob_full, ldq_full, stq_full  input  1 each  allocation targets cannot take an entry this cycle
- rob_alloc, ldq_alloc, stq_alloc  output  1 each  allocate-one-entry strobes
- out_valid  output  1  head instruction is dispatchable
- out_ready  input  1  downstream accepts
- out_control_signals  output  control_signal_bus  head instruction's control signals
- out_immediate, out_pc  output  XLEN each  head instruction's immediate and PC
- dispatched_count  output  CNT_W  instructions dispatched since reset
- stall_count  output  CNT_W  cycles the head was blocked by a full structure

## Operation
- Storage: a head register and a skid register, each with a valid bit. States follow the valid bits: EMPTY, ONE (head only), TWO (head and skid).
- `accept` = in_valid && in_ready && !flush.
- Resource check on the head: `res_ok` = !(alloc_rob_entry && rob_full) && !(alloc_ldq_entry && ldq_full) && !(alloc_stq_entry && stq_full).
- out_valid = head_valid && res_ok && !flush.
- `fire` = out_valid && out_ready.
- Allocate strobes are asserted only in a fire cycle:
  - rob_alloc = fire && alloc_rob_entry
  - ldq_alloc = fire && alloc_ldq_entry
  - stq_alloc = fire && alloc_stq_entry
- in_ready = !skid_valid, registered state only, with no combinational path from out_ready or the full flags.
- State transitions:
  - EMPTY, accept → ONE.
  - ONE, accept without fire → TWO (input goes to skid).
  - ONE, accept with fire → ONE (input replaces head).
  - ONE, fire without accept → EMPTY.
  - TWO, fire → ONE (skid moves to head). No accept is possible in TWO.
- flush has priority over everything: next state is EMPTY, the input is dropped, no fire or allocate that cycle, and in_ready is 1 on the following cycle.
- Outputs out_control_signals, out_immediate and out_pc always reflect the head register, even when not valid.
- Counters wrap modulo 2^CNT_W:
  - dispatched_count increments on fire.
  - stall_count increments when head_valid && !res_ok && !flush.
  - Neither counter is cleared by flush.

## Timing
- Reset (asynchronous assert, synchronous release): both valid bits 0, head/skid payload 0, counters 0.
  - Output values: out_valid 0, all alloc strobes 0, in_ready 1, out_* payload 0.
- Latency: an instruction accepted at edge N is presented on out_valid in cycle N+1 at the earliest.
- Throughput is one instruction per cycle sustained when out_ready=1 and no structure is full.
- A full structure stalls only instructions that need it. A load is not blocked by stq_full.
- Reset asserted mid-operation discards all held instructions immediately. No strobe may glitch high during reset.

## Structure
- control_signal_bus stays in the shared decode package. Add a packed `dispatch_entry_t` {control_signal_bus, immediate, pc} to the same package.
- One natural sub-module: `skid_buffer` (parameterised on payload type/width, with valid/ready and flush). dispatch_stage wraps it with the resource gating, strobes and counters.

## Test plan
- Back-to-back stream: 8 ALU instructions (opcode 0110011), out_ready=1, no full flags → out_valid from cycle 1, eight consecutive fires, rob_alloc pulsed 8 times, ldq/stq_alloc never, dispatched_count=8.
- Backpressure: out_ready=0 for 3 cycles during a stream → in_ready drops the cycle after the second instruction is held. No instruction is lost or duplicated (check PCs 0x0,0x4,0x8 in order).
- Selective stall: head is a load (opcode 0000011) with ldq_full=1 for 5 cycles → out_valid=0, stall_count=5. Then ldq_full=0 → fire with rob_alloc=1, ldq_alloc=1. A store with ldq_full=1 dispatches without stall.
- Flush in TWO state with in_valid=1 → next cycle out_valid=0 and in_ready=1. No alloc strobe in the flush cycle. The input from the flush cycle never appears.
- Async reset mid-stream (reset_n low between edges) → outputs reach reset values immediately. After release, the first accepted instruction dispatches with correct payload and counters restart from 0.
- Counter wrap with CNT_W=4: 17 dispatches → dispatched_count=1.
